// File: rtl/ex_muldiv_seq_if.sv
// Request/response bundle between the EX-stage decode and the iterative
// multiply/divide sequencer.
interface ex_muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        dz;
  logic        z;
  logic        n;

  modport master (
    output start, op, a, b, flush,
    input  stall, busy, done, result_lo, result_hi, dz, z, n
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, busy, done, result_lo, result_hi, dz, z, n
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Radix-2 iterative multiply / restoring divide for the EX stage: 32 loop
// cycles on operand magnitudes, sign fix-up, one-cycle done pulse.
module ex_muldiv_seq (
  input  logic           clk,
  input  logic           R,
  ex_muldiv_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] mag_q;
  logic [31:0] acc_hi_q, acc_lo_q;
  logic        qneg_q, rneg_q;
  logic        done_q, dz_q, z_q, n_q;
  logic [31:0] res_lo_q, res_hi_q;

  logic        is_div, is_sgn;
  logic [32:0] sum_mul;
  logic [32:0] rem_sh;
  logic        take_sub;
  logic [31:0] sub_lo;
  logic [31:0] acc_hi_d, acc_lo_d;
  logic [31:0] fix_hi_d, fix_lo_d;

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign is_div = op_q[1];
  assign is_sgn = op_q[0];

  // One loop iteration: MUL shifts the {hi,lo} product right after a
  // conditional add; DIV shifts the dividend into the remainder and
  // subtracts the divisor when it fits.
  always_comb begin
    sum_mul  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : 33'd0);
    rem_sh   = {acc_hi_q, acc_lo_q[31]};
    take_sub = (rem_sh >= {1'b0, mag_q});
    sub_lo   = 32'(rem_sh - {1'b0, mag_q});
    if (is_div) begin
      acc_hi_d = take_sub ? sub_lo : rem_sh[31:0];
      acc_lo_d = {acc_lo_q[30:0], take_sub};
    end else begin
      acc_hi_d = sum_mul[32:1];
      acc_lo_d = {sum_mul[0], acc_lo_q[31:1]};
    end
  end

  // Sign fix-up of the magnitude result
  always_comb begin
    if (is_div) begin
      fix_hi_d = neg32(acc_hi_q, rneg_q);
      fix_lo_d = neg32(acc_lo_q, qneg_q);
    end else begin
      {fix_hi_d, fix_lo_d} = neg64({acc_hi_q, acc_lo_q}, qneg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            state_q <= PREP;
          end
        end
        PREP: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else if (is_div && (b_q == 32'd0)) begin
            res_lo_q <= 32'hFFFF_FFFF;
            res_hi_q <= a_q;
            dz_q     <= 1'b1;
            z_q      <= 1'b0;
            n_q      <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            mag_q    <= is_div ? mag32(b_q, is_sgn) : mag32(a_q, is_sgn);
            acc_lo_q <= is_div ? mag32(a_q, is_sgn) : mag32(b_q, is_sgn);
            acc_hi_q <= '0;
            qneg_q   <= is_sgn & (a_q[31] ^ b_q[31]);
            rneg_q   <= is_sgn & is_div & a_q[31];
            cnt_q    <= 6'd31;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            if (cnt_q == 6'd0) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        FIX: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            res_lo_q <= fix_lo_d;
            res_hi_q <= fix_hi_d;
            dz_q     <= 1'b0;
            z_q      <= (fix_lo_d == 32'd0);
            n_q      <= fix_lo_d[31];
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
  assign bus.stall     = (bus.start && (state_q == IDLE)) || bus.busy;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.dz        = dz_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
endmodule
